m_pc_ctrl: RTL and testbench

Fetch-side program-counter and pipeline-flush controller: the consumer of the stall and redirect requests raised by the hazard detection unit. It owns the PC register, the instruction-memory fetch handshake, the IF/ID write enable, the per-stage flush pulses and the WFI sleep state. It sits at the head of the pipeline, between the hazard unit, the CSR/trap unit and the instruction memory port.

---
 rtl/m_pc_ctrl.sv | 138 +++++++++++++
 tb/tb_m_pc_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/m_pc_ctrl.sv
// rtl/m_pc_ctrl.sv - fetch-side PC register, redirect/flush control and WFI sleep
//
// Owns the program counter and the instruction-memory fetch handshake.
// Stall and redirect requests come from the hazard unit, the EX stage and the
// CSR/trap unit. Per-stage bubble pulses are driven here, and the core sleeps
// here on WFI.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   PCWrite_i             0 = hold PC
//   IF_Dwrite_i           0 = hold IF/ID
//   exe_pc_req_i/_pc_i    EX branch/jump redirect and target
//   csr_pc_req_i/_pc_i    trap/mret redirect and target
//   wfi_req_i             WFI reached EX
//   irq_pending_i         enabled interrupt pending (level)
//   imem_ready_i          fetch response valid this cycle
//   pc_o                  current fetch address
//   fetch_req_o           fetch request valid
//   if_id_en_o            IF/ID write enable
//   if_id_flush_o         bubble into IF/ID
//   id_ex_flush_o         bubble into ID/EX
//   ex_mem_flush_o        bubble into EX/MEM
//   wfi_sleep_o           core asleep in WFI
module m_pc_ctrl #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            PCWrite_i,
   input  logic            IF_Dwrite_i,
   input  logic            exe_pc_req_i,
   input  logic [XLEN-1:0] exe_pc_i,
   input  logic            csr_pc_req_i,
   input  logic [XLEN-1:0] csr_pc_i,
   input  logic            wfi_req_i,
   input  logic            irq_pending_i,
   input  logic            imem_ready_i,
   output logic [XLEN-1:0] pc_o,
   output logic            fetch_req_o,
   output logic            if_id_en_o,
   output logic            if_id_flush_o,
   output logic            id_ex_flush_o,
   output logic            ex_mem_flush_o,
   output logic            wfi_sleep_o
);

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_KILL = 2'd1,
      ST_WFI  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            wfi_sleep_q, wfi_sleep_d;

   // A redirect while a request is in flight without a response leaves a
   // stale response behind; KILL waits for it and discards it.
   logic            fetch_pending;
   state_t          redir_state;

   assign fetch_req_o   = (state_q != ST_WFI);
   assign fetch_pending = fetch_req_o & ~imem_ready_i;
   assign redir_state   = fetch_pending ? ST_KILL : ST_RUN;

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      if_id_flush_o  = 1'b0;
      id_ex_flush_o  = 1'b0;
      ex_mem_flush_o = 1'b0;
      // Outside WFI, imem_ready_i in KILL only occurs on the stale-response
      // cycle, where the concurrent flush turns the write into a bubble.
      if_id_en_o     = ~rst_i & fetch_req_o & IF_Dwrite_i & imem_ready_i;

      if (rst_i) begin
         state_d = ST_RUN;
         pc_d    = RESET_VECTOR;
      end else if (csr_pc_req_i) begin
         pc_d           = {csr_pc_i[XLEN-1:2], 2'b00};
         if_id_flush_o  = 1'b1;
         id_ex_flush_o  = 1'b1;
         ex_mem_flush_o = 1'b1;
         state_d        = redir_state;
      end else if (exe_pc_req_i && state_q != ST_WFI) begin
         pc_d          = {exe_pc_i[XLEN-1:2], 2'b00};
         if_id_flush_o = 1'b1;
         id_ex_flush_o = 1'b1;
         state_d       = redir_state;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (wfi_req_i && !irq_pending_i) begin
                  state_d = ST_WFI;
               end else if (PCWrite_i && imem_ready_i) begin
                  pc_d = pc_q + XLEN'(4);
               end
            end
            ST_KILL: begin
               // pc_q already holds the redirect target; never advance here.
               if (imem_ready_i) begin
                  if_id_flush_o = 1'b1;
               end
               if (wfi_req_i && !irq_pending_i) begin
                  state_d = ST_WFI;
               end else if (imem_ready_i) begin
                  state_d = ST_RUN;
               end
            end
            ST_WFI: begin
               if (irq_pending_i) begin
                  state_d = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end

      wfi_sleep_d = (state_d == ST_WFI);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_RUN;
         pc_q        <= RESET_VECTOR;
         wfi_sleep_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         wfi_sleep_q <= wfi_sleep_d;
      end
   end

   assign pc_o        = pc_q;
   assign wfi_sleep_o = wfi_sleep_q;

endmodule

// File: tb/tb_m_pc_ctrl.sv
// tb/tb_m_pc_ctrl.sv - directed self-checking bench for m_pc_ctrl
module tb_m_pc_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        pcwrite, ifdwrite, exe_req, csr_req, wfi_req, irq, ready;
   logic [31:0] exe_pc, csr_pc;
   logic [31:0] pc;
   logic        fetch_req, if_id_en, if_id_flush, id_ex_flush, ex_mem_flush, wfi_sleep;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   m_pc_ctrl dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .PCWrite_i      (pcwrite),
      .IF_Dwrite_i    (ifdwrite),
      .exe_pc_req_i   (exe_req),
      .exe_pc_i       (exe_pc),
      .csr_pc_req_i   (csr_req),
      .csr_pc_i       (csr_pc),
      .wfi_req_i      (wfi_req),
      .irq_pending_i  (irq),
      .imem_ready_i   (ready),
      .pc_o           (pc),
      .fetch_req_o    (fetch_req),
      .if_id_en_o     (if_id_en),
      .if_id_flush_o  (if_id_flush),
      .id_ex_flush_o  (id_ex_flush),
      .ex_mem_flush_o (ex_mem_flush),
      .wfi_sleep_o    (wfi_sleep)
   );

   // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; pcwrite = 1'b1; ifdwrite = 1'b1; exe_req = 1'b0; csr_req = 1'b0;
      wfi_req = 1'b0; irq = 1'b0; ready = 1'b0; exe_pc = '0; csr_pc = '0;
      tick(); tick();
      rst = 1'b0;
      settle();
      checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h8000_0000); end
      checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL reset_fetch_req got=%b exp=1", fetch_req); end
      checks++; if (wfi_sleep !== 1'b0) begin errors++; $display("FAIL reset_wfi_sleep got=%b exp=0", wfi_sleep); end
      checks++; if ({if_id_flush, id_ex_flush, ex_mem_flush} !== 3'b000) begin errors++; $display("FAIL reset_flush got=%b exp=000", {if_id_flush, id_ex_flush, ex_mem_flush}); end
      checks++; if (if_id_en !== 1'b0) begin errors++; $display("FAIL reset_if_id_en got=%b exp=0", if_id_en); end
   endtask

   task automatic test_sequential();
      ready = 1'b1;
      settle();
      checks++; if (if_id_en !== 1'b1) begin errors++; $display("FAIL seq_if_id_en got=%b exp=1", if_id_en); end
      tick();
      checks++; if (pc !== 32'h8000_0004) begin errors++; $display("FAIL seq_pc1 got=%h exp=%h", pc, 32'h8000_0004); end
      tick();
      checks++; if (pc !== 32'h8000_0008) begin errors++; $display("FAIL seq_pc2 got=%h exp=%h", pc, 32'h8000_0008); end
      tick();
      checks++; if (pc !== 32'h8000_000C) begin errors++; $display("FAIL seq_pc3 got=%h exp=%h", pc, 32'h8000_000C); end
      ready = 1'b0;
      tick();
      checks++; if (pc !== 32'h8000_000C) begin errors++; $display("FAIL seq_hold_notready got=%h exp=%h", pc, 32'h8000_000C); end
      ready = 1'b1; pcwrite = 1'b0;
      tick();
      checks++; if (pc !== 32'h8000_000C) begin errors++; $display("FAIL seq_hold_pcwrite got=%h exp=%h", pc, 32'h8000_000C); end
      pcwrite = 1'b1;
   endtask

   task automatic test_exe_redirect();
      exe_req = 1'b1; exe_pc = 32'h8000_0103; ready = 1'b1;
      settle();
      checks++; if ({if_id_flush, id_ex_flush, ex_mem_flush} !== 3'b110) begin errors++; $display("FAIL exe_flush got=%b exp=110", {if_id_flush, id_ex_flush, ex_mem_flush}); end
      tick();
      exe_req = 1'b0;
      checks++; if (pc !== 32'h8000_0100) begin errors++; $display("FAIL exe_pc got=%h exp=%h", pc, 32'h8000_0100); end
      tick();
      checks++; if (pc !== 32'h8000_0104) begin errors++; $display("FAIL exe_run_advance got=%h exp=%h", pc, 32'h8000_0104); end
   endtask

   task automatic test_kill();
      exe_req = 1'b1; exe_pc = 32'h8000_0200; ready = 1'b0;
      tick();
      exe_req = 1'b0;
      checks++; if (pc !== 32'h8000_0200) begin errors++; $display("FAIL kill_pc got=%h exp=%h", pc, 32'h8000_0200); end
      tick();
      checks++; if (if_id_flush !== 1'b0) begin errors++; $display("FAIL kill_wait_flush got=%b exp=0", if_id_flush); end
      ready = 1'b1;
      settle();
      checks++; if ({if_id_flush, id_ex_flush} !== 2'b10) begin errors++; $display("FAIL kill_stale_flush got=%b exp=10", {if_id_flush, id_ex_flush}); end
      tick();
      checks++; if (pc !== 32'h8000_0200) begin errors++; $display("FAIL kill_no_inc got=%h exp=%h", pc, 32'h8000_0200); end
      settle();
      checks++; if (if_id_flush !== 1'b0) begin errors++; $display("FAIL kill_back_run_flush got=%b exp=0", if_id_flush); end
      tick();
      checks++; if (pc !== 32'h8000_0204) begin errors++; $display("FAIL kill_advance got=%h exp=%h", pc, 32'h8000_0204); end
      // redirect while already in KILL
      exe_req = 1'b1; exe_pc = 32'h8000_0300; ready = 1'b0;
      tick();
      exe_pc = 32'h8000_0400;
      tick();
      exe_req = 1'b0;
      checks++; if (pc !== 32'h8000_0400) begin errors++; $display("FAIL kill_reredirect_pc got=%h exp=%h", pc, 32'h8000_0400); end
      ready = 1'b1;
      settle();
      checks++; if (if_id_flush !== 1'b1) begin errors++; $display("FAIL kill_reredirect_stale got=%b exp=1", if_id_flush); end
      tick();
      checks++; if (pc !== 32'h8000_0400) begin errors++; $display("FAIL kill_reredirect_hold got=%h exp=%h", pc, 32'h8000_0400); end
      tick();
      checks++; if (pc !== 32'h8000_0404) begin errors++; $display("FAIL kill_reredirect_adv got=%h exp=%h", pc, 32'h8000_0404); end
   endtask

   task automatic test_simultaneous();
      exe_req = 1'b1; exe_pc = 32'h8000_0300; csr_req = 1'b1; csr_pc = 32'h8000_0040; ready = 1'b1;
      settle();
      checks++; if ({if_id_flush, id_ex_flush, ex_mem_flush} !== 3'b111) begin errors++; $display("FAIL simul_flush got=%b exp=111", {if_id_flush, id_ex_flush, ex_mem_flush}); end
      tick();
      exe_req = 1'b0; csr_req = 1'b0;
      checks++; if (pc !== 32'h8000_0040) begin errors++; $display("FAIL simul_pc got=%h exp=%h", pc, 32'h8000_0040); end
   endtask

   task automatic test_wfi();
      wfi_req = 1'b1; irq = 1'b0; ready = 1'b1;
      tick();
      wfi_req = 1'b0;
      checks++; if (wfi_sleep !== 1'b1) begin errors++; $display("FAIL wfi_sleep got=%b exp=1", wfi_sleep); end
      checks++; if (fetch_req !== 1'b0) begin errors++; $display("FAIL wfi_fetch_req got=%b exp=0", fetch_req); end
      checks++; if (if_id_en !== 1'b0) begin errors++; $display("FAIL wfi_if_id_en got=%b exp=0", if_id_en); end
      for (int i = 0; i < 10; i++) begin
         checks++; if (pc !== 32'h8000_0040) begin errors++; $display("FAIL wfi_frozen[%0d] got=%h exp=%h", i, pc, 32'h8000_0040); end
         tick();
      end
      exe_req = 1'b1; exe_pc = 32'h8000_0600;
      settle();
      checks++; if (id_ex_flush !== 1'b0) begin errors++; $display("FAIL wfi_exe_ignored_flush got=%b exp=0", id_ex_flush); end
      tick();
      exe_req = 1'b0;
      checks++; if (pc !== 32'h8000_0040) begin errors++; $display("FAIL wfi_exe_ignored_pc got=%h exp=%h", pc, 32'h8000_0040); end
      irq = 1'b1;
      tick();
      checks++; if (fetch_req !== 1'b1) begin errors++; $display("FAIL wfi_exit_fetch got=%b exp=1", fetch_req); end
      checks++; if (wfi_sleep !== 1'b0) begin errors++; $display("FAIL wfi_exit_sleep got=%b exp=0", wfi_sleep); end
      checks++; if (pc !== 32'h8000_0040) begin errors++; $display("FAIL wfi_exit_pc got=%h exp=%h", pc, 32'h8000_0040); end
      // WFI with an interrupt already pending behaves as a NOP
      wfi_req = 1'b1;
      tick();
      wfi_req = 1'b0; irq = 1'b0;
      checks++; if (wfi_sleep !== 1'b0) begin errors++; $display("FAIL wfi_nop_sleep got=%b exp=0", wfi_sleep); end
      checks++; if (pc !== 32'h8000_0044) begin errors++; $display("FAIL wfi_nop_pc got=%h exp=%h", pc, 32'h8000_0044); end
   endtask

   task automatic test_wrap();
      csr_req = 1'b1; csr_pc = 32'hFFFF_FFFE; ready = 1'b1;
      tick();
      csr_req = 1'b0;
      checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_target got=%h exp=%h", pc, 32'hFFFF_FFFC); end
      tick();
      checks++; if (pc !== 32'h0000_0000) begin errors++; $display("FAIL wrap_zero got=%h exp=%h", pc, 32'h0000_0000); end
   endtask

   task automatic test_reset_mid_kill();
      exe_req = 1'b1; exe_pc = 32'h8000_0500; ready = 1'b0;
      tick();
      exe_req = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL rstkill_pc got=%h exp=%h", pc, 32'h8000_0000); end
      ready = 1'b1;
      settle();
      checks++; if (if_id_flush !== 1'b0) begin errors++; $display("FAIL rstkill_no_kill got=%b exp=0", if_id_flush); end
      tick();
      checks++; if (pc !== 32'h8000_0004) begin errors++; $display("FAIL rstkill_advance got=%h exp=%h", pc, 32'h8000_0004); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_exe_redirect();
      test_kill();
      test_simultaneous();
      test_wfi();
      test_wrap();
      test_reset_mid_kill();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
